// File: rtl/mport_ram.sv
// Multi-port RAM: zero-fills on reset, then serves NPORTS read/write ports; reads return one cycle after accept (read-first).
// Reads are never stalled; same-address write collisions are arbitrated round-robin and losers see ready low and must hold.
module mport_ram #(
  parameter int NPORTS = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        valid,
  output logic [NPORTS-1:0]        ready,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] data,
  output logic [NPORTS*DATA_W-1:0] q,
  output logic [NPORTS-1:0]        q_valid,
  output logic                     init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int PW    = $clog2(NPORTS);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [PW-1:0]     rr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] a [NPORTS];
  logic [DATA_W-1:0] d [NPORTS];
  logic [PW-1:0]     win [NPORTS];
  logic [NPORTS-1:0] wr_req;
  logic [NPORTS-1:0] conflict;
  logic [NPORTS-1:0] wr_go;
  logic [NPORTS-1:0] rd_go;
  logic              found;
  int                idx;
  logic              have_conf;
  logic [ADDR_W-1:0] conf_addr;
  logic [PW-1:0]     conf_win;
  logic [PW-1:0]     rr_next;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      a[i]      = addr[i*ADDR_W +: ADDR_W];
      d[i]      = data[i*DATA_W +: DATA_W];
      wr_req[i] = valid[i] & we[i];
    end
  end

  // Each writer finds the first same-address writer scanning upward from rr_ptr.
  always_comb begin
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NPORTS; i++) begin
      win[i]      = PW'(i);
      conflict[i] = 1'b0;
      found       = 1'b0;
      for (int k = 0; k < NPORTS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        if (wr_req[i] && wr_req[idx] && (a[idx] == a[i])) begin
          if (!found) begin
            win[i] = PW'(idx);
            found  = 1'b1;
          end
          if (idx != i) conflict[i] = 1'b1;
        end
      end
    end
  end

  // The lowest-address conflict group decides how the pointer moves.
  always_comb begin
    have_conf = 1'b0;
    conf_addr = '0;
    conf_win  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (conflict[i] && (!have_conf || (a[i] < conf_addr))) begin
        have_conf = 1'b1;
        conf_addr = a[i];
        conf_win  = win[i];
      end
    end
    rr_next = (conf_win == PW'(NPORTS-1)) ? '0 : conf_win + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      ready[i] = (state == RUN) && !(wr_req[i] && (win[i] != PW'(i)));
    end
    wr_go = ready & wr_req;
    rd_go = ready & valid & ~we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rr_ptr    <= '0;
      q_valid   <= '0;
      q         <= '0;
    end else begin
      case (state)
        INIT: begin
          q_valid  <= '0;
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          q_valid <= rd_go;
          for (int i = 0; i < NPORTS; i++) begin
            if (rd_go[i]) q[i*DATA_W +: DATA_W] <= mem[a[i]];
          end
          if (have_conf) rr_ptr <= rr_next;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Winners always target distinct addresses, so the per-port writes never collide.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (wr_go[i]) mem[a[i]] <= d[i];
      end
    end
  end

endmodule

// File: doc/mport_ram.md
MPORT_RAM -- requirements
Module: mport_ram

Interface
REQ-001 SHALL have parameter NPORTS, default 2: number of independent access ports, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 6: address width; depth is DEPTH = 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port valid, input, NPORTS: per-port request valid, bit i for port i.
REQ-007 SHALL have port ready, output, NPORTS: per-port request accept.
REQ-008 SHALL have port we, input, NPORTS: per-port write enable (1 = write, 0 = read).
REQ-009 SHALL have port addr, input, NPORTS*ADDR_W: port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port data, input, NPORTS*DATA_W: write data, port i at [i*DATA_W +: DATA_W].
REQ-011 SHALL have port q, output, NPORTS*DATA_W: registered read data, port i at [i*DATA_W +: DATA_W].
REQ-012 SHALL have port q_valid, output, NPORTS: one-cycle pulse marking q of port i valid.
REQ-013 SHALL have port init_done, output, 1: high once memory clear has completed.

Function
REQ-014 SHALL implement a two-state FSM, INIT and RUN; reset forces INIT.
REQ-015 In INIT, SHALL write zero to address init_cnt each cycle, init_cnt counting 0..DEPTH-1; on the cycle writing DEPTH-1, SHALL move to RUN and set init_done.
REQ-016 In INIT, SHALL hold ready = 0 and ignore all requests.
REQ-017 A request on port i SHALL be accepted on a rising edge where valid[i] & ready[i] = 1.
REQ-018 In RUN, ready[i] for a read SHALL be 1, regardless of other ports.
REQ-019 In RUN, ready[i] for a write SHALL be 1 unless another port j also has valid[j] & we[j] with the same address and wins arbitration.
REQ-020 ready SHALL be combinational from valid, we, addr, FSM state and rr_ptr only.
REQ-021 Write-write conflicts SHALL be resolved round-robin: the winner is the first conflicting port at or after rr_ptr, searching cyclically upward.
REQ-022 rr_ptr (width clog2(NPORTS), reset 0) SHALL advance to (winner+1) mod NPORTS after any cycle with a write conflict, and hold otherwise.
REQ-023 Multiple conflict groups (different addresses) in one cycle SHALL each be arbitrated with the same rr_ptr; rr_ptr SHALL advance using the winner of the lowest-address group.
REQ-024 Non-conflicting writes to distinct addresses SHALL all commit in the same cycle.
REQ-025 An accepted read SHALL present mem[addr] on q one cycle later, with q_valid[i] = 1 for exactly that cycle.
REQ-026 A read and an accepted write to the same address in the same cycle SHALL return the pre-write data (read-first).
REQ-027 q[i] SHALL hold its last value when q_valid[i] = 0.
REQ-028 A losing writer SHALL see ready[i] = 0 and is expected to hold its request; the block SHALL NOT buffer it.
REQ-029 Addresses SHALL be full-range; there is no out-of-range condition.

Reset
REQ-030 While rst = 1, SHALL force ready = 0, q = 0, q_valid = 0, init_done = 0, rr_ptr = 0, init_cnt = 0, and state INIT.
REQ-031 Reset assertion mid-operation SHALL abandon in-flight reads (no q_valid pulse) and restart INIT, re-zeroing all DEPTH locations.
REQ-032 After rst falls, init_done SHALL rise exactly DEPTH cycles later, and first acceptance SHALL be possible on the following edge.

Verification
REQ-033 Init check (NPORTS=3, DATA_W=8, ADDR_W=4): release rst, count cycles -> init_done high after 16 cycles; reads of all 16 addresses return 0x00.
REQ-034 Parallel access: port0 writes 0xA5@3, port1 writes 0x5A@7, port2 reads 3 the next cycle -> both writes accepted in one cycle; port2 q = 0xA5 with q_valid pulse one cycle after acceptance.
REQ-035 Read-first: port0 writes 0x11@5 (old 0x22) while port1 reads 5 in the same cycle -> port1 q = 0x22; a later read returns 0x11.
REQ-036 Round-robin: all 3 ports write @9 (0x01, 0x02, 0x03), held until accepted, rr_ptr = 0 -> accept order port0, port1, port2 on consecutive cycles; final mem[9] = 0x03; repeat with port0 persistently re-requesting -> port0 does not win twice in succession.
REQ-037 Reset mid-read: assert rst the cycle after a read is accepted -> no q_valid pulse, q = 0, init_done = 0; after 16 cycles, memory reads back 0x00.
